stdp_stochastic_updater: RTL and testbench

- Downstream consumer of the free-running 16-bit maximal-length LFSR.
- Uses the LFSR's pseudo-random word to apply Bernoulli-gated STDP weight updates to one column of N synapses.
- Walks the synapses serially, one per clock. Each step compares the current random word against a per-case probability threshold, then saturating-increments or decrements that synapse's weight.
- Sits between the column's spike-time capture logic (upstream) and the weight-consuming neuron body (downstream).

---
 rtl/stdp_stochastic_updater.sv | 149 ++++++++++++++
 tb/tb_stdp_stochastic_updater.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/stdp_stochastic_updater.sv
// rtl/stdp_stochastic_updater.sv - Serial Bernoulli-gated STDP weight updater for one synapse column
module stdp_stochastic_updater #(
    parameter int          N          = 16,
    parameter int          TW         = 4,
    parameter int          WW         = 3,
    parameter int          WMAX       = 7,
    parameter int          WINIT      = 4,
    parameter logic [15:0] MU_CAPTURE = 16'h8000,
    parameter logic [15:0] MU_MINUS   = 16'h4000,
    parameter logic [15:0] MU_SEARCH  = 16'h0400,
    parameter logic [15:0] MU_BACKOFF = 16'h8000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [N*TW-1:0] in_time,
    input  logic [TW-1:0]   out_time,
    input  logic [15:0]     rand_val,
    output logic [N*WW-1:0] weights,
    output logic            busy,
    output logic            done
);

    localparam int            IW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST    = IW'(N - 1);
    localparam logic [TW-1:0] INF     = '1;
    localparam logic [WW-1:0] WMAX_W  = WW'(WMAX);
    localparam logic [WW-1:0] WINIT_W = WW'(WINIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [IW-1:0]     r_idx;
    logic [N*TW-1:0]   r_in_snap;
    logic [TW-1:0]     r_out_snap;
    logic [N*WW-1:0]   r_weights;

    logic [TW-1:0]     w_in;
    logic [WW-1:0]     w_cur;
    logic [WW-1:0]     w_new;
    logic              w_in_inf;
    logic              w_out_inf;
    logic              w_inc;
    logic              w_dec;

    assign w_in      = r_in_snap[r_idx*TW +: TW];
    assign w_cur     = r_weights[r_idx*WW +: WW];
    assign w_in_inf  = (w_in == INF);
    assign w_out_inf = (r_out_snap == INF);
    assign weights   = r_weights;

    // State register; reset abandons any pass in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and status outputs; start is only looked at in IDLE.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                busy = 1'b1;
                if (r_idx == LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Pick the STDP case for the current synapse and roll the Bernoulli trial against rand_val.
    always_comb begin
        w_inc = 1'b0;
        w_dec = 1'b0;
        if (!w_in_inf && !w_out_inf) begin
            if (w_in <= r_out_snap) begin
                w_inc = (rand_val < MU_CAPTURE);
            end else begin
                w_dec = (rand_val < MU_MINUS);
            end
        end else if (!w_in_inf) begin
            w_inc = (rand_val < MU_SEARCH);
        end else if (!w_out_inf) begin
            w_dec = (rand_val < MU_BACKOFF);
        end
    end

    // Saturating step of the selected weight; never wraps.
    always_comb begin
        w_new = w_cur;
        if (w_inc && (w_cur < WMAX_W)) begin
            w_new = w_cur + WW'(1);
        end else if (w_dec && (w_cur != '0)) begin
            w_new = w_cur - WW'(1);
        end
    end

    // Snapshot inputs on accepted start, then walk one synapse per cycle writing its weight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_in_snap  <= '0;
            r_out_snap <= '0;
            r_weights  <= {N{WINIT_W}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_in_snap  <= in_time;
                        r_out_snap <= out_time;
                        r_idx      <= '0;
                    end
                end
                S_SCAN: begin
                    r_weights[r_idx*WW +: WW] <= w_new;
                    if (r_idx != LAST) begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stdp_stochastic_updater.sv
// tb/tb_stdp_stochastic_updater.sv - Directed table-driven bench for stdp_stochastic_updater
module tb_stdp_stochastic_updater;

    localparam int N  = 16;
    localparam int TW = 4;
    localparam int WW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [N*TW-1:0] in_time;
    logic [TW-1:0]   out_time;
    logic [15:0]     rand_val;

    logic [N*WW-1:0] w_ff, w_def, w_zero;
    logic            busy_ff, busy_def, busy_zero;
    logic            done_ff, done_def, done_zero;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    stdp_stochastic_updater #(
        .MU_CAPTURE(16'hFFFF), .MU_MINUS(16'hFFFF),
        .MU_SEARCH(16'hFFFF),  .MU_BACKOFF(16'hFFFF)
    ) dut_ff (
        .clk(clk), .rst(rst), .start(start), .in_time(in_time), .out_time(out_time),
        .rand_val(rand_val), .weights(w_ff), .busy(busy_ff), .done(done_ff)
    );

    stdp_stochastic_updater dut_def (
        .clk(clk), .rst(rst), .start(start), .in_time(in_time), .out_time(out_time),
        .rand_val(rand_val), .weights(w_def), .busy(busy_def), .done(done_def)
    );

    stdp_stochastic_updater #(
        .MU_CAPTURE(16'h0000)
    ) dut_zero (
        .clk(clk), .rst(rst), .start(start), .in_time(in_time), .out_time(out_time),
        .rand_val(rand_val), .weights(w_zero), .busy(busy_zero), .done(done_zero)
    );

    typedef struct {
        logic [3:0]  in0;
        logic [3:0]  outt;
        logic [15:0] rv;
        int          e0_ff, e0_def, e0_zero;
        int          er_ff, er_def, er_zero;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    endtask

    function automatic int wof(input logic [N*WW-1:0] w, input int i);
        return int'(w[i*WW +: WW]);
    endfunction

    // Returns exp if synapses 1..N-1 all hold exp, otherwise the first differing weight.
    function automatic int rest_val(input logic [N*WW-1:0] w, input int exp);
        for (int i = 1; i < N; i++) begin
            if (wof(w, i) != exp) return wof(w, i);
        end
        return exp;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input logic [3:0] in0, input logic [3:0] outt, input logic [15:0] rv);
        in_time      = '1;
        in_time[3:0] = in0;
        out_time     = outt;
        rand_val     = rv;
    endtask

    task automatic run_pass(output int cycles);
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cycles = 0;
        while (done_ff !== 1'b1 && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    initial begin
        int cyc;
        int dones;
        rst = 1'b1;
        start = 1'b0;
        set_inputs(4'hF, 4'hF, 16'h0000);

        vecs[0]  = '{4'd2,  4'd5,  16'h0001, 5, 5, 4, 3, 3, 3};
        vecs[1]  = '{4'd9,  4'd5,  16'h0001, 3, 3, 3, 3, 3, 3};
        vecs[2]  = '{4'd15, 4'd15, 16'h0000, 4, 4, 4, 4, 4, 4};
        vecs[3]  = '{4'd2,  4'd5,  16'h7FFF, 5, 5, 4, 3, 3, 3};
        vecs[4]  = '{4'd2,  4'd5,  16'h8000, 5, 4, 4, 3, 4, 4};
        vecs[5]  = '{4'd5,  4'd5,  16'h0000, 5, 5, 4, 3, 3, 3};
        vecs[6]  = '{4'd3,  4'd15, 16'h03FF, 5, 5, 5, 4, 4, 4};
        vecs[7]  = '{4'd3,  4'd15, 16'h0400, 5, 4, 4, 4, 4, 4};
        vecs[8]  = '{4'd15, 4'd5,  16'h7FFF, 3, 3, 3, 3, 3, 3};
        vecs[9]  = '{4'd15, 4'd5,  16'h8000, 3, 4, 4, 3, 4, 4};
        vecs[10] = '{4'd15, 4'd15, 16'hFFFF, 4, 4, 4, 4, 4, 4};
        vecs[11] = '{4'd9,  4'd5,  16'h4000, 3, 4, 4, 3, 3, 3};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_w0", wof(w_ff, 0), 4);
        check("reset_rest", rest_val(w_ff, 4), 4);
        check("reset_busy", int'(busy_ff), 0);
        check("reset_done", int'(done_ff), 0);

        // Reset during SCAN at idx 5 drops busy immediately and restores WINIT.
        do_reset();
        set_inputs(4'd2, 4'd5, 16'h0001);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrun_w0_before_rst", wof(w_ff, 0), 5);
        rst = 1'b1;
        #1;
        check("midrun_rst_busy", int'(busy_ff), 0);
        check("midrun_rst_done", int'(done_ff), 0);
        check("midrun_rst_w0", wof(w_ff, 0), 4);
        check("midrun_rst_rest", rest_val(w_ff, 4), 4);
        @(posedge clk);
        #1;
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk);
            #1;
            if (done_ff === 1'b1) dones++;
        end
        check("midrun_no_done", dones, 0);
        check("midrun_w0_after", wof(w_ff, 0), 4);

        // Table of single-pass vectors applied to all three threshold sets.
        for (int v = 0; v < 12; v++) begin
            do_reset();
            set_inputs(vecs[v].in0, vecs[v].outt, vecs[v].rv);
            run_pass(cyc);
            check($sformatf("v%0d_latency", v), cyc, N);
            check($sformatf("v%0d_w0_ff", v), wof(w_ff, 0), vecs[v].e0_ff);
            check($sformatf("v%0d_w0_def", v), wof(w_def, 0), vecs[v].e0_def);
            check($sformatf("v%0d_w0_zero", v), wof(w_zero, 0), vecs[v].e0_zero);
            check($sformatf("v%0d_rest_ff", v), rest_val(w_ff, vecs[v].er_ff), vecs[v].er_ff);
            check($sformatf("v%0d_rest_def", v), rest_val(w_def, vecs[v].er_def), vecs[v].er_def);
            check($sformatf("v%0d_rest_zero", v), rest_val(w_zero, vecs[v].er_zero), vecs[v].er_zero);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_busy_after", v), int'(busy_ff), 0);
            check($sformatf("v%0d_done_after", v), int'(done_ff), 0);
        end

        // Saturation at WMAX under repeated capture.
        do_reset();
        set_inputs(4'd2, 4'd5, 16'h0001);
        for (int p = 1; p <= 5; p++) begin
            run_pass(cyc);
            @(posedge clk);
            #1;
            check($sformatf("sat_hi_pass%0d", p), wof(w_ff, 0), (4 + p > 7) ? 7 : 4 + p);
        end

        // Saturation at zero under repeated backoff.
        do_reset();
        set_inputs(4'd15, 4'd5, 16'h0001);
        for (int p = 1; p <= 6; p++) begin
            run_pass(cyc);
            @(posedge clk);
            #1;
            check($sformatf("sat_lo_pass%0d", p), wof(w_ff, 0), (4 - p < 0) ? 0 : 4 - p);
        end

        // Start while busy and input changes mid-pass are ignored.
        do_reset();
        set_inputs(4'd2, 4'd5, 16'h0001);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dones = 0;
        cyc   = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            start = (c == 2);
            if (c == 2) set_inputs(4'd9, 4'd15, 16'h0001);
            if (done_ff === 1'b1) begin
                dones++;
                if (cyc == 0) cyc = c;
            end
        end
        start = 1'b0;
        check("busy_start_done_count", dones, 1);
        check("busy_start_done_cycle", cyc, N);
        check("busy_start_w0", wof(w_ff, 0), 5);
        check("busy_start_rest", rest_val(w_ff, 3), 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
